// File: rtl/spi_master.sv
// SPI master, mode 0 (clock idles low, data launched on the low phase and sampled at the
// end of the high phase). Transfers one byte per send request, MSB first, with programmable
// chip-select setup, hold and idle gap. Every output comes straight from a flop.
module spi_master #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_IDLE  = 4
) (
    input  logic       sysClk,
    input  logic       reset_n,
    input  logic       send,
    input  logic [7:0] tx_byte,
    output logic [7:0] rx_byte,
    output logic       busy,
    output logic       done,
    output logic       spiClk,
    output logic       cs,
    output logic       mosi,
    input  logic       miso
);

    // Reject parameter values whose reload constants would not fit the 8-bit counter.
    if (CLK_DIV < 2 || CLK_DIV > 255 || CS_SETUP < 1 || CS_SETUP > 255 ||
        CS_HOLD < 1 || CS_HOLD > 255 || CS_IDLE < 1 || CS_IDLE > 255) begin : g_param_check
        $error("spi_master: parameter out of range");
    end

    // Counters are loaded with length-1 on state entry and the state exits when they hit zero.
    localparam logic [7:0] DivM1   = 8'(CLK_DIV - 1);
    localparam logic [7:0] SetupM1 = 8'(CS_SETUP - 1);
    localparam logic [7:0] HoldM1  = 8'(CS_HOLD - 1);
    localparam logic [7:0] IdleM1  = 8'(CS_IDLE - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StLow,
        StHigh,
        StHold,
        StGap
    } state_e;

    state_e     state_q;
    logic [7:0] cnt_q;
    logic [2:0] bit_idx_q;
    logic [6:0] tx_sh_q;    // bits still to send after the one currently on mosi
    logic [7:0] rx_sh_q;
    logic [7:0] rx_byte_q;
    logic       busy_q;
    logic       done_q;
    logic       spi_clk_q;
    logic       cs_q;
    logic       mosi_q;
    logic       start_now;

    // A transfer starts from idle, or on the very edge the idle gap expires so that a held
    // send request yields exactly CS_IDLE cycles of cs high between transfers.
    always_comb begin
        start_now = 1'b0;
        if (send) begin
            if (state_q == StIdle) begin
                start_now = 1'b1;
            end else if (state_q == StGap && cnt_q == 8'd0) begin
                start_now = 1'b1;
            end
        end
    end

    // Transfer sequencer with registered outputs.
    always_ff @(posedge sysClk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            bit_idx_q <= 3'd0;
            tx_sh_q   <= 7'd0;
            rx_sh_q   <= 8'd0;
            rx_byte_q <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            spi_clk_q <= 1'b0;
            cs_q      <= 1'b1;
            mosi_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_now) begin
                state_q   <= StSetup;
                cnt_q     <= SetupM1;
                bit_idx_q <= 3'd7;
                tx_sh_q   <= tx_byte[6:0];
                mosi_q    <= tx_byte[7];
                cs_q      <= 1'b0;
                busy_q    <= 1'b1;
                spi_clk_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        busy_q <= 1'b0;
                    end
                    StSetup: begin
                        if (cnt_q != 8'd0) begin
                            cnt_q <= cnt_q - 8'd1;
                        end else begin
                            state_q <= StLow;
                            cnt_q   <= DivM1;
                        end
                    end
                    StLow: begin
                        if (cnt_q != 8'd0) begin
                            cnt_q <= cnt_q - 8'd1;
                        end else begin
                            state_q   <= StHigh;
                            cnt_q     <= DivM1;
                            spi_clk_q <= 1'b1;
                        end
                    end
                    StHigh: begin
                        if (cnt_q != 8'd0) begin
                            cnt_q <= cnt_q - 8'd1;
                        end else begin
                            // Sample miso on the edge that ends the high phase.
                            rx_sh_q   <= {rx_sh_q[6:0], miso};
                            spi_clk_q <= 1'b0;
                            if (bit_idx_q != 3'd0) begin
                                state_q   <= StLow;
                                cnt_q     <= DivM1;
                                bit_idx_q <= bit_idx_q - 3'd1;
                                mosi_q    <= tx_sh_q[6];
                                tx_sh_q   <= {tx_sh_q[5:0], 1'b0};
                            end else begin
                                state_q <= StHold;
                                cnt_q   <= HoldM1;
                            end
                        end
                    end
                    StHold: begin
                        if (cnt_q != 8'd0) begin
                            cnt_q <= cnt_q - 8'd1;
                        end else begin
                            state_q   <= StGap;
                            cnt_q     <= IdleM1;
                            cs_q      <= 1'b1;
                            done_q    <= 1'b1;
                            rx_byte_q <= rx_sh_q;
                        end
                    end
                    StGap: begin
                        if (cnt_q != 8'd0) begin
                            cnt_q <= cnt_q - 8'd1;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign rx_byte = rx_byte_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign spiClk  = spi_clk_q;
    assign cs      = cs_q;
    assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: stimulus pushes expected transfer results, monitors pop and
// compare them whenever a DUT raises done. Two instances: defaults, and a fast configuration
// talking to a slave model that shifts 8'h5A out on spiClk falling edges.
module tb_spi_master;

    typedef struct {
        logic [7:0] rx;
        logic [7:0] tx;
        int         done_cyc;
        int         gap;
    } exp_t;

    logic       sysClk = 1'b0;
    logic       reset_n = 1'b0;
    logic       send1 = 1'b0;
    logic [7:0] tx1 = 8'h00;
    logic [7:0] rx1;
    logic       busy1, done1, sck1, cs1, mosi1, miso1;
    logic       miso_tie1 = 1'b0;

    logic       send2 = 1'b0;
    logic [7:0] tx2 = 8'h00;
    logic [7:0] rx2;
    logic       busy2, done2, sck2, cs2, mosi2;
    logic       miso2 = 1'b0;
    logic [7:0] slave_sh = 8'h00;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    exp_t q1[$];
    exp_t q2[$];

    always #5 sysClk = ~sysClk;
    always @(posedge sysClk) cyc <= cyc + 1;

    assign miso1 = miso_tie1 ? 1'b1 : mosi1;

    spi_master u_dut (
        .sysClk (sysClk),
        .reset_n(reset_n),
        .send   (send1),
        .tx_byte(tx1),
        .rx_byte(rx1),
        .busy   (busy1),
        .done   (done1),
        .spiClk (sck1),
        .cs     (cs1),
        .mosi   (mosi1),
        .miso   (miso1)
    );

    spi_master #(
        .CLK_DIV (2),
        .CS_SETUP(1),
        .CS_HOLD (1),
        .CS_IDLE (4)
    ) u_dut2 (
        .sysClk (sysClk),
        .reset_n(reset_n),
        .send   (send2),
        .tx_byte(tx2),
        .rx_byte(rx2),
        .busy   (busy2),
        .done   (done2),
        .spiClk (sck2),
        .cs     (cs2),
        .mosi   (mosi2),
        .miso   (miso2)
    );

    // Slave model: presents MSB when selected, next bit on each spiClk falling edge.
    always @(negedge cs2) begin
        slave_sh = 8'h5A;
        miso2    = slave_sh[7];
    end
    always @(negedge sck2) begin
        #1;
        slave_sh = {slave_sh[6:0], 1'b0};
        miso2    = slave_sh[7];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sysClk);
        #1;
    endtask

    // Monitor for the default instance: tracks cs-low length, spiClk rises, mosi bits, gaps.
    int         low_cnt = 0, rises = 0, gap_run = 0, gap_seen = 0;
    logic [7:0] mosi_sh = 8'h00;
    logic       cs_prev = 1'b1, sck_prev = 1'b0, done_prev = 1'b0;
    always @(negedge sysClk) begin
        exp_t e;
        if (!cs1 && cs_prev) begin
            gap_seen = gap_run;
            low_cnt  = 0;
            rises    = 0;
            mosi_sh  = 8'h00;
        end
        if (!cs1) begin
            low_cnt++;
            if (sck1 && !sck_prev) begin
                rises++;
                mosi_sh = {mosi_sh[6:0], mosi1};
            end
        end else begin
            gap_run = cs_prev ? gap_run + 1 : 1;
        end
        if (done_prev) check("done_width", {31'd0, done1}, 32'd0);
        if (done1) begin
            if (q1.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                e = q1.pop_front();
                check("rx_byte", {24'd0, rx1}, {24'd0, e.rx});
                check("done_cycle", cyc, e.done_cyc);
                check("mosi_bits", {24'd0, mosi_sh}, {24'd0, e.tx});
                check("sck_rises", rises, 8);
                check("cs_low_cycles", low_cnt, 68);
                if (e.gap > 0) check("cs_gap", gap_seen, e.gap);
            end
        end
        cs_prev   = cs1;
        sck_prev  = sck1;
        done_prev = done1;
    end

    // Monitor for the fast instance.
    logic [7:0] mosi2_sh = 8'h00;
    logic       cs2_prev = 1'b1, sck2_prev = 1'b0;
    always @(negedge sysClk) begin
        exp_t e;
        if (!cs2 && cs2_prev) mosi2_sh = 8'h00;
        if (!cs2 && sck2 && !sck2_prev) mosi2_sh = {mosi2_sh[6:0], mosi2};
        if (done2) begin
            if (q2.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done2: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                e = q2.pop_front();
                check("rx_byte2", {24'd0, rx2}, {24'd0, e.rx});
                check("done_cycle2", cyc, e.done_cyc);
                check("mosi_bits2", {24'd0, mosi2_sh}, {24'd0, e.tx});
            end
        end
        cs2_prev  = cs2;
        sck2_prev = sck2;
    end

    // Single-cycle send on the default instance; done lands 1 + 2 + 64 + 2 edges after the
    // cycle send is first driven.
    task automatic xfer1(input logic [7:0] tx, input logic tie_high, input logic [7:0] rx);
        exp_t e;
        miso_tie1 = tie_high;
        tx1       = tx;
        send1     = 1'b1;
        e         = '{rx: rx, tx: tx, done_cyc: cyc + 69, gap: 0};
        q1.push_back(e);
        step(1);
        send1 = 1'b0;
        step(80);
    endtask

    initial begin
        exp_t e;
        int   k;

        // Reset state.
        step(3);
        check("rst_cs", {31'd0, cs1}, 32'd1);
        check("rst_sck", {31'd0, sck1}, 32'd0);
        check("rst_mosi", {31'd0, mosi1}, 32'd0);
        check("rst_busy", {31'd0, busy1}, 32'd0);
        check("rst_done", {31'd0, done1}, 32'd0);
        check("rst_rx", {24'd0, rx1}, 32'd0);
        reset_n = 1'b1;
        step(2);

        // Fast instance against the 8'h5A slave: 1 + 1 + 32 + 1 = 35 edges.
        tx2   = 8'hC3;
        send2 = 1'b1;
        e     = '{rx: 8'h5A, tx: 8'hC3, done_cyc: cyc + 35, gap: 0};
        q2.push_back(e);
        step(1);
        send2 = 1'b0;
        step(60);
        check("busy2_idle", {31'd0, busy2}, 32'd0);

        // Loopback and tied-high miso.
        xfer1(8'hA5, 1'b0, 8'hA5);
        xfer1(8'h3C, 1'b1, 8'hFF);

        // Extra send pulses during SETUP, LOW and HIGH, with tx_byte changing, are ignored.
        miso_tie1 = 1'b0;
        tx1       = 8'h81;
        send1     = 1'b1;
        e         = '{rx: 8'h81, tx: 8'h81, done_cyc: cyc + 69, gap: 0};
        q1.push_back(e);
        step(1);
        tx1 = 8'hFF;
        step(1);
        send1 = 1'b0;
        step(2);
        send1 = 1'b1;
        tx1   = 8'h7E;
        step(1);
        send1 = 1'b0;
        step(3);
        send1 = 1'b1;
        tx1   = 8'h00;
        step(1);
        send1 = 1'b0;
        step(80);

        // Send held for 200 cycles: transfers every 72 cycles with a 4-cycle cs-high gap.
        tx1   = 8'h96;
        send1 = 1'b1;
        k     = cyc;
        e     = '{rx: 8'h96, tx: 8'h96, done_cyc: k + 69, gap: 0};
        q1.push_back(e);
        e     = '{rx: 8'h96, tx: 8'h96, done_cyc: k + 141, gap: 4};
        q1.push_back(e);
        e     = '{rx: 8'h96, tx: 8'h96, done_cyc: k + 213, gap: 4};
        q1.push_back(e);
        step(200);
        send1 = 1'b0;
        step(40);

        // Reset pulse during the bit-3 high phase aborts with no done.
        tx1   = 8'hE7;
        send1 = 1'b1;
        step(1);
        send1 = 1'b0;
        step(39);
        check("pre_rst_sck_high", {31'd0, sck1}, 32'd1);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        check("abort_cs", {31'd0, cs1}, 32'd1);
        check("abort_sck", {31'd0, sck1}, 32'd0);
        check("abort_busy", {31'd0, busy1}, 32'd0);
        check("abort_rx", {24'd0, rx1}, 32'd0);
        check("abort_done", {31'd0, done1}, 32'd0);
        check("abort_mosi", {31'd0, mosi1}, 32'd0);
        step(100);

        // Reset and send together: reset wins.
        tx1     = 8'h55;
        send1   = 1'b1;
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b0;
        send1   = 1'b0;
        reset_n = 1'b1;
        check("rst_send_busy", {31'd0, busy1}, 32'd0);
        check("rst_send_cs", {31'd0, cs1}, 32'd1);
        step(5);
        check("rst_send_cs_later", {31'd0, cs1}, 32'd1);

        check("pending_q1", q1.size(), 32'd0);
        check("pending_q2", q2.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
